mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin arbiter and select sequencer for the shared 4-to-1 data mux built from 2-to-1 mux stages. Four requesters compete for the mux output; the block grants one at a time, drives the mux select pair, bounds grant length with a hold timeout, and enforces a one-cycle break-before-make gap so the select never changes while the output is marked valid.

## Interface

Parameters:
- HOLD_MAX, 8: maximum cycles a grant may be held (legal 2..255).
- CNT_W, 8: hold counter width; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- Clk  input  1  rising-edge clock; the block's only clock.
- Rst  input  1  asynchronous, active-high reset.
- Req  input  4  request lines; Req[i] high means requester i wants the mux.
- Release  input  1  current owner finished; sampled only in GRANT.
- Gnt  output  4  one-hot grant, registered; all zero when no grant is active.
- Sel  output  2  mux select; Sel[1] drives the output stage, Sel[0] the input stage; equals the granted index.
- Valid  output  1  mux output belongs to the owner; high exactly while Gnt is non-zero.
- Timeout  output  1  one-cycle pulse marking a grant ended by HOLD_MAX.

## Operation

- Reset values: Gnt=0000, Sel=00, Valid=0, Timeout=0, round-robin pointer Ptr=0, hold counter=0, state IDLE. Rst is asynchronous: asserting it mid-grant clears all outputs immediately, with no Timeout pulse.
- States: IDLE, GRANT.
- IDLE: Gnt=0, Valid=0, Sel holds its last value. If any Req bit is high at a clock edge, the winner is the first set bit searched in order Ptr, Ptr+1, Ptr+2, Ptr+3 (mod 4). At that edge: Gnt=one-hot(winner), Sel=winner, Valid=1, counter=1, state GRANT. With no request, the block stays in IDLE.
- GRANT: Gnt, Sel, and Valid are stable. The counter increments each cycle. The grant ends at an edge where any of the following holds:
  - Release=1, or
  - Req[owner]=0 (treated as a release), or
  - counter==HOLD_MAX.
- Grant end, at that edge: Gnt=0, Valid=0, Ptr=(owner+1) mod 4, counter=0, state IDLE. Timeout=1 for the following cycle only if the end was caused solely by the counter.
- Release or a Req drop in the same cycle as counter==HOLD_MAX is a normal release; Timeout stays 0.
- Requests from other requesters during GRANT are ignored until IDLE. They are not latched; Req must still be high when sampled in IDLE.
- A requester that keeps Req high after its grant ends is re-eligible, but at the lowest priority because of the pointer advance.
- Gnt is never multi-hot. Sel changes only on the edge leaving IDLE.

## Timing

- Arbitration latency: Req sampled high in IDLE at edge k gives Gnt/Valid high after edge k.
- Grant length is 1..HOLD_MAX cycles. A grant that is never released lasts exactly HOLD_MAX cycles.
- Valid is low for at least one full cycle between consecutive grants. Back-to-back grant throughput is one grant per (hold+1) cycles.
- Timeout coincides with the first IDLE cycle after a timed-out grant and is never high while Valid=1.
- Release sampled at edge k drops Gnt/Valid after edge k. The next grant can appear after edge k+1.
- All outputs are registered. There are no combinational paths from Req or Release to any output.

## Test plan

- Reset: hold Rst=1 with Req=1111, then release -> Gnt=0000, Sel=00, Valid=0 during reset. Gnt=0001 one edge after Rst drops.
- Rotation: Req=1111 held, Release pulsed each grant's 2nd cycle -> grant order 0,1,2,3,0, each Sel matching, one Valid-low cycle between grants.
- Timeout: HOLD_MAX=8, Req=0100 held, Release=0 -> Gnt=0100 for exactly 8 cycles, then Gnt=0000 and Timeout=1 for one cycle, then Gnt=0100 again.
- Tie at limit: Release=1 on the cycle where the counter reaches HOLD_MAX -> grant ends, Timeout stays 0.
- Req drop and pointer: Ptr=2 with Req=1011, then requester 3 drops Req mid-grant -> grant ends next edge. Next winner is 0 (search order 0,1,2 from Ptr=0), not 1.
- Async reset mid-grant: Rst pulsed between edges during Gnt=1000 -> outputs clear without waiting for a clock edge, Ptr=0, no Timeout pulse.

Source files
------------

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between the four mux requesters and the round-robin arbiter.
// The slave side is the arbiter; the master side drives requests and observes grants.
interface mux4_rr_arbiter_if;
  logic [3:0] Req;
  logic       Release;
  logic [3:0] Gnt;
  logic [1:0] Sel;
  logic       Valid;
  logic       Timeout;

  modport slave (
    input  Req,
    input  Release,
    output Gnt,
    output Sel,
    output Valid,
    output Timeout
  );

  modport master (
    output Req,
    output Release,
    input  Gnt,
    input  Sel,
    input  Valid,
    input  Timeout
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and select sequencer for a 4:1 mux built from 2:1 stages.
// One grant at a time, hold bounded by HOLD_MAX, one idle cycle between grants.
module mux4_rr_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic                Clk,
  input  logic                Rst,
  mux4_rr_arbiter_if.slave    bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         gnt_q, gnt_d;
  logic [1:0]         sel_q, sel_d;
  logic               valid_q, valid_d;
  logic               timeout_q, timeout_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               win_vld;
  logic [1:0]         win_idx;
  logic [1:0]         cand;
  logic               rel_end;
  logic               lim_end;

  // Scan from the far end so the candidate closest to ptr_q wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    cand    = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (bus.Req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // A dropped request from the owner ends the grant just like Release.
  assign rel_end = bus.Release | ~bus.Req[sel_q];
  assign lim_end = (cnt_q == CNT_W'(HOLD_MAX));

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          gnt_d   = 4'(4'b0001 << win_idx);
          sel_d   = win_idx;
          valid_d = 1'b1;
          cnt_d   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (rel_end || lim_end) begin
          state_d   = IDLE;
          gnt_d     = 4'b0000;
          valid_d   = 1'b0;
          ptr_d     = sel_q + 2'd1;
          cnt_d     = '0;
          timeout_d = lim_end & ~rel_end;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      sel_q     <= 2'b00;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= 2'b00;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.Gnt     = gnt_q;
  assign bus.Sel     = sel_q;
  assign bus.Valid   = valid_q;
  assign bus.Timeout = timeout_q;

  a_gnt_onehot0: assert property (@(posedge Clk) disable iff (Rst) $onehot0(gnt_q));
  a_valid_gnt:   assert property (@(posedge Clk) disable iff (Rst) valid_q == (|gnt_q));
  a_to_not_vld:  assert property (@(posedge Clk) disable iff (Rst) !(timeout_q && valid_q));

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus random traffic
// compared every cycle against a behavioural round-robin model.
module tb_mux4_rr_arbiter;
  localparam int HOLD_MAX = 8;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(
    .HOLD_MAX (HOLD_MAX),
    .CNT_W    (8)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: owner index (-1 = none), cycles held, pointer, last select.
  int m_owner = -1;
  int m_len   = 0;
  int m_ptr   = 0;
  int m_sel   = 0;
  bit m_to    = 1'b0;
  int m_idx;
  bit m_rel;
  bit m_lim;

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      m_owner = -1;
      m_len   = 0;
      m_ptr   = 0;
      m_sel   = 0;
      m_to    = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        for (int k = 0; k < 4; k++) begin
          m_idx = (m_ptr + k) % 4;
          if (m_owner < 0 && bus.Req[m_idx]) begin
            m_owner = m_idx;
            m_sel   = m_idx;
            m_len   = 1;
          end
        end
      end else begin
        m_rel = bus.Release || !bus.Req[m_owner];
        m_lim = (m_len == HOLD_MAX);
        if (m_rel || m_lim) begin
          m_to    = m_lim && !m_rel;
          m_ptr   = (m_owner + 1) % 4;
          m_owner = -1;
          m_len   = 0;
        end else begin
          m_len = m_len + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [7:0] e_gnt;
    e_gnt = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
    chk("gnt",     8'(bus.Gnt),     e_gnt);
    chk("sel",     8'(bus.Sel),     8'(m_sel));
    chk("valid",   8'(bus.Valid),   8'(m_owner >= 0));
    chk("timeout", 8'(bus.Timeout), 8'(m_to));
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
    compare_all();
  endtask

  function automatic int owner_of(input logic [3:0] g);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  int  order[$];
  int  exp_order[5];
  bit  prev_valid;
  bit  tie;
  bit  tie_seen;
  int  guard;

  initial begin
    exp_order = '{0, 1, 2, 3, 0};
    Rst = 1'b1;
    bus.Req = 4'b1111;
    bus.Release = 1'b0;

    // Reset held with all requests pending
    repeat (3) step();
    Rst = 1'b0;
    step();
    chk("rst_first_gnt", 8'(bus.Gnt), 8'h01);

    // Rotation with Release on each grant's second cycle
    order.push_back(owner_of(bus.Gnt));
    prev_valid = bus.Valid;
    guard = 0;
    while (order.size() < 5 && guard < 40) begin
      bus.Release = (m_owner >= 0 && m_len == 2);
      step();
      if (bus.Valid && !prev_valid) order.push_back(owner_of(bus.Gnt));
      prev_valid = bus.Valid;
      guard++;
    end
    chk("rot_count", 8'(order.size()), 8'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < order.size()) chk("rot_order", 8'(order[i]), 8'(exp_order[i]));
    end
    bus.Release = 1'b0;
    bus.Req = 4'b0000;

    // Timeout: single requester never releasing
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    bus.Req = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("to_gnt", 8'(bus.Gnt), (i == 8) ? 8'h00 : 8'h04);
      chk("to_flag", 8'(bus.Timeout), 8'(i == 8));
    end

    // Release coinciding with the hold limit
    tie_seen = 1'b0;
    guard = 0;
    while (!tie_seen && guard < 20) begin
      bus.Release = (m_owner >= 0 && m_len == HOLD_MAX);
      tie = bus.Release;
      step();
      if (tie) begin
        tie_seen = 1'b1;
        chk("tie_gnt", 8'(bus.Gnt), 8'h00);
        chk("tie_to", 8'(bus.Timeout), 8'h00);
      end
      guard++;
    end
    chk("tie_seen", 8'(tie_seen), 8'h01);
    bus.Release = 1'b0;
    bus.Req = 4'b0000;

    // Req drop with pointer at 2
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    bus.Req = 4'b0010;
    step();
    chk("drop_own1", 8'(bus.Gnt), 8'h02);
    bus.Release = 1'b1;
    step();
    bus.Release = 1'b0;
    bus.Req = 4'b1011;
    step();
    chk("drop_win3", 8'(bus.Gnt), 8'h08);
    step();
    bus.Req = 4'b0011;
    step();
    chk("drop_end", 8'(bus.Gnt), 8'h00);
    step();
    chk("drop_next0", 8'(bus.Gnt), 8'h01);
    bus.Req = 4'b0000;

    // Asynchronous reset between edges during a grant to requester 3
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    bus.Req = 4'b1000;
    step();
    chk("async_pre", 8'(bus.Gnt), 8'h08);
    step();
    @(posedge Clk);
    #2 Rst = 1'b1;
    #1;
    chk("async_gnt", 8'(bus.Gnt), 8'h00);
    chk("async_valid", 8'(bus.Valid), 8'h00);
    chk("async_sel", 8'(bus.Sel), 8'h00);
    chk("async_to", 8'(bus.Timeout), 8'h00);
    #1 Rst = 1'b0;
    bus.Req = 4'b1111;
    @(negedge Clk);
    compare_all();
    step();
    chk("async_ptr0", 8'(bus.Gnt), 8'h01);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) bus.Req = 4'($urandom_range(0, 15));
      bus.Release = ($urandom_range(0, 7) == 0);
      Rst = ($urandom_range(0, 499) == 0);
      step();
      chk("inv_to_valid", 8'(bus.Timeout && bus.Valid), 8'h00);
    end
    Rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
